// File: rtl/mdio_pkg.sv
// Shared constants, frame field positions and FSM encoding for the MDIO initiator.
package mdio_pkg;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;

   localparam int unsigned ST_MSB  = 31;
   localparam int unsigned ST_LSB  = 30;
   localparam int unsigned OP_MSB  = 29;
   localparam int unsigned OP_LSB  = 28;

   localparam int unsigned FRAME_BITS    = 32;
   localparam int unsigned RD_DRIVE_BITS = 14;
   localparam int unsigned RD_IN_BITS    = 18;
   localparam int unsigned TA_BITS       = 2;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StShiftOut,
      StShiftIn,
      StDone
   } mdio_state_e;

   function automatic logic frame_valid(input logic [31:0] frame);
      return (frame[ST_MSB:ST_LSB] == ST_CODE) &&
             ((frame[OP_MSB:OP_LSB] == OP_WR) || (frame[OP_MSB:OP_LSB] == OP_RD));
   endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: MDC_DIV clocks low then MDC_DIV clocks high per bit, with strobes that
// fire on the clock before MDC rises or falls. Held low while disabled.
module mdc_gen #(
   parameter int unsigned MDC_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic mdc_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CntW = $clog2(MDC_DIV) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MDC_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mdc_q, mdc_d;
   logic            wrap;

   always_comb begin
      wrap  = en_i && (cnt_q == CntMax);
      cnt_d = '0;
      mdc_d = 1'b0;
      if (en_i) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
         mdc_d = wrap ? ~mdc_q : mdc_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

   assign mdc_o  = mdc_q;
   assign rise_o = wrap && !mdc_q;
   assign fall_o = wrap && mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// Clause-22 MDIO initiator: optional preamble, frame shift-out, and 16-bit read-back.
module mdio_controller
   import mdio_pkg::*;
#(
   parameter int unsigned MDC_DIV      = 2,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OE,
   output logic        MDIO_OUT,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        BUSY,
   output logic        ERR
);

   localparam logic [5:0] LastPre = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);

   mdio_state_e state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        is_rd_q, is_rd_d;
   logic        oe_q, oe_d;
   logic        out_q, out_d;
   logic        data_rdy_q, data_rdy_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        mdc_rise, mdc_fall;

   mdc_gen #(
      .MDC_DIV(MDC_DIV)
   ) u_mdc_gen (
      .clk_i (CLK),
      .rst_i (RESET),
      .en_i  (busy_q),
      .mdc_o (MDC),
      .rise_o(mdc_rise),
      .fall_o(mdc_fall)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      is_rd_d    = is_rd_q;
      oe_d       = oe_q;
      out_d      = out_q;
      busy_d     = busy_q;
      data_rdy_d = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (MDIO_START) begin
               if (frame_valid(T_DATA)) begin
                  tx_d      = T_DATA;
                  is_rd_d   = (T_DATA[OP_MSB:OP_LSB] == OP_RD);
                  busy_d    = 1'b1;
                  bit_cnt_d = '0;
                  oe_d      = 1'b1;
                  if (PREAMBLE_LEN == 0) begin
                     state_d = StShiftOut;
                     out_d   = T_DATA[31];
                  end else begin
                     state_d = StPreamble;
                     out_d   = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StPreamble: begin
            if (mdc_fall) begin
               if (bit_cnt_q == LastPre) begin
                  state_d   = StShiftOut;
                  bit_cnt_d = '0;
                  out_d     = tx_q[31];
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         StShiftOut: begin
            if (mdc_fall) begin
               tx_d = {tx_q[30:0], 1'b0};
               if (!is_rd_q && (bit_cnt_q == 6'(FRAME_BITS - 1))) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
               end else if (is_rd_q && (bit_cnt_q == 6'(RD_DRIVE_BITS - 1))) begin
                  state_d   = StShiftIn;
                  bit_cnt_d = '0;
                  oe_d      = 1'b0;
                  out_d     = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  out_d     = tx_q[30];
               end
            end
         end
         StShiftIn: begin
            // Turnaround samples are dropped; the last rise precedes the final fall,
            // so rx_q is complete when the frame ends.
            if (mdc_rise && (bit_cnt_q >= 6'(TA_BITS))) begin
               rx_d = {rx_q[14:0], MDIO_IN};
            end
            if (mdc_fall) begin
               if (bit_cnt_q == 6'(RD_IN_BITS - 1)) begin
                  state_d    = StDone;
                  busy_d     = 1'b0;
                  rd_data_d  = rx_q;
                  data_rdy_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         is_rd_q    <= 1'b0;
         oe_q       <= 1'b0;
         out_q      <= 1'b0;
         data_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         is_rd_q    <= is_rd_d;
         oe_q       <= oe_d;
         out_q      <= out_d;
         data_rdy_q <= data_rdy_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign MDIO_OE  = oe_q;
   assign MDIO_OUT = out_q;
   assign RD_DATA  = rd_data_q;
   assign DATA_RDY = data_rdy_q;
   assign BUSY     = busy_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: two instances (no preamble / 32-bit preamble), a cycle-level
// frame model plus a peripheral that decodes MDC/MDIO and answers reads.
module tb_mdio_controller;

   localparam int D = 2;

   logic        clk;
   logic        rst;
   logic        start   [2];
   logic [31:0] tdata   [2];
   logic        mdio_in [2];
   logic        mdc     [2];
   logic        oe      [2];
   logic        out     [2];
   logic        drdy    [2];
   logic        busy    [2];
   logic        err     [2];
   logic [15:0] rdd     [2];

   int n_cmp = 0;
   int n_fail = 0;

   // Frame model state, advanced on every posedge.
   bit          m_act  [2];
   bit          m_done [2];
   bit          m_rd   [2];
   bit          m_err  [2];
   int          m_k    [2];
   logic [31:0] m_t    [2];
   logic [15:0] m_resp [2];
   logic [15:0] m_rdd  [2];

   // Peripheral-side observations.
   logic [63:0] cap   [2];
   int          capn  [2];
   int          busyn [2];
   int          risen [2];
   int          errn  [2];
   int          drn   [2];
   logic        pmdc  [2];

   mdio_controller #(.MDC_DIV(D), .PREAMBLE_LEN(0)) dut0 (
      .CLK(clk), .RESET(rst), .MDIO_START(start[0]), .T_DATA(tdata[0]), .MDIO_IN(mdio_in[0]),
      .MDC(mdc[0]), .MDIO_OE(oe[0]), .MDIO_OUT(out[0]), .RD_DATA(rdd[0]),
      .DATA_RDY(drdy[0]), .BUSY(busy[0]), .ERR(err[0])
   );

   mdio_controller #(.MDC_DIV(D), .PREAMBLE_LEN(32)) dut1 (
      .CLK(clk), .RESET(rst), .MDIO_START(start[1]), .T_DATA(tdata[1]), .MDIO_IN(mdio_in[1]),
      .MDC(mdc[1]), .MDIO_OE(oe[1]), .MDIO_OUT(out[1]), .RD_DATA(rdd[1]),
      .DATA_RDY(drdy[1]), .BUSY(busy[1]), .ERR(err[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pre_of(input int i);
      return (i == 0) ? 0 : 32;
   endfunction

   function automatic void chk(input string name, input int i, input logic [63:0] act,
                               input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, i, $time, act, exp);
      end
   endfunction

   function automatic void exp_pins(input int i, output logic e_mdc, output logic e_oe,
                                    output logic e_out);
      int ph, b, j;
      ph    = (m_k[i] - 1) % (2 * D);
      b     = (m_k[i] - 1) / (2 * D);
      e_mdc = (ph >= D);
      if (b < pre_of(i)) begin
         e_oe  = 1'b1;
         e_out = 1'b1;
      end else begin
         j = b - pre_of(i);
         if (!m_rd[i] || j < 14) begin
            e_oe  = 1'b1;
            e_out = m_t[i][31-j];
         end else begin
            e_oe  = 1'b0;
            e_out = 1'b0;
         end
      end
   endfunction

   // Peripheral response: turnaround driven to 1 so a stray sample would corrupt RD_DATA.
   function automatic logic periph_bit(input int i);
      int b, j;
      if (!m_act[i] || !m_rd[i]) return 1'b0;
      b = (m_k[i] - 1) / (2 * D);
      j = b - pre_of(i);
      if (j >= 16) return m_resp[i][31-j];
      if (j >= 14) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0;
            if (rst) begin
               m_act[i]  = 1'b0;
               m_done[i] = 1'b0;
               m_rdd[i]  = 16'h0;
            end else if (m_done[i]) begin
               m_done[i] = 1'b0;
            end else if (m_act[i]) begin
               m_k[i]++;
               if (m_k[i] > (pre_of(i) + 32) * 2 * D) begin
                  m_act[i]  = 1'b0;
                  m_done[i] = 1'b1;
                  if (m_rd[i]) m_rdd[i] = m_resp[i];
               end
            end else if (start[i]) begin
               if (tdata[i][31:30] == 2'b01 &&
                   (tdata[i][29:28] == 2'b01 || tdata[i][29:28] == 2'b10)) begin
                  m_act[i] = 1'b1;
                  m_k[i]   = 1;
                  m_t[i]   = tdata[i];
                  m_rd[i]  = (tdata[i][29:28] == 2'b10);
                  cap[i]   = '0;
                  capn[i]  = 0;
                  busyn[i] = 0;
               end else begin
                  m_err[i] = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      logic e_mdc, e_oe, e_out, e_busy;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
               exp_pins(i, e_mdc, e_oe, e_out);
               e_busy = 1'b1;
            end else begin
               e_mdc  = 1'b0;
               e_oe   = 1'b0;
               e_out  = 1'b0;
               e_busy = 1'b0;
            end
            chk("MDC", i, 64'(mdc[i]), 64'(e_mdc));
            chk("MDIO_OE", i, 64'(oe[i]), 64'(e_oe));
            chk("MDIO_OUT", i, 64'(out[i]), 64'(e_out));
            chk("BUSY", i, 64'(busy[i]), 64'(e_busy));
            chk("DATA_RDY", i, 64'(drdy[i]), 64'(m_done[i] && m_rd[i]));
            chk("ERR", i, 64'(err[i]), 64'(m_err[i]));
            chk("RD_DATA", i, 64'(rdd[i]), 64'(m_rdd[i]));

            if (mdc[i] === 1'b1 && pmdc[i] === 1'b0) begin
               risen[i]++;
               if (oe[i]) begin
                  cap[i] = {cap[i][62:0], out[i]};
                  capn[i]++;
               end
            end
            pmdc[i] = mdc[i];
            if (busy[i]) busyn[i]++;
            if (err[i]) errn[i]++;
            if (drdy[i]) drn[i]++;
            mdio_in[i] = periph_bit(i);
         end
      end
   end

   task automatic issue(input int i, input logic [31:0] t, input logic [15:0] resp);
      m_resp[i] = resp;
      tdata[i]  = t;
      start[i]  = 1'b1;
      @(posedge clk);
      #1;
      start[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input string name);
      int n = 0;
      while ((m_act[i] || m_done[i] || busy[i]) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_done_in_time"}, i, 64'(n < 3000), 64'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int r0, e0, d0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; tdata[i] = '0; mdio_in[i] = 1'b0;
         cap[i] = '0; capn[i] = 0; busyn[i] = 0; risen[i] = 0; errn[i] = 0; drn[i] = 0;
         pmdc[i] = 1'b0; m_act[i] = 1'b0; m_done[i] = 1'b0; m_rd[i] = 1'b0; m_err[i] = 1'b0;
         m_k[i] = 0; m_t[i] = '0; m_resp[i] = '0; m_rdd[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_busy", 0, 64'(busy[0]), 64'(0));
      chk("reset_rd_data", 1, 64'(rdd[1]), 64'(0));

      // Write, no preamble.
      d0 = drn[0];
      issue(0, 32'h50C2ABCD, 16'h0);
      wait_idle(0, "t1");
      chk("t1_busy_cycles", 0, 64'(busyn[0]), 64'(128));
      chk("t1_oe_bits", 0, 64'(capn[0]), 64'(32));
      chk("t1_phy", 0, 64'(cap[0][27:23]), 64'(5'd1));
      chk("t1_reg", 0, 64'(cap[0][22:18]), 64'(5'h10));
      chk("t1_wdata", 0, 64'(cap[0][15:0]), 64'(16'hABCD));
      chk("t1_no_drdy", 0, 64'(drn[0] - d0), 64'(0));

      // Read, peripheral answers 1234.
      d0 = drn[0];
      issue(0, 32'h60C00000, 16'h1234);
      wait_idle(0, "t2");
      chk("t2_driven_bits", 0, 64'(capn[0]), 64'(14));
      chk("t2_header", 0, 64'(cap[0][13:0]), 64'(14'h1830));
      chk("t2_rd_data", 0, 64'(rdd[0]), 64'(16'h1234));
      chk("t2_drdy_pulses", 0, 64'(drn[0] - d0), 64'(1));
      chk("t2_busy_cycles", 0, 64'(busyn[0]), 64'(128));

      // Write with preamble.
      issue(1, 32'h50C20001, 16'h0);
      wait_idle(1, "t3");
      chk("t3_busy_cycles", 1, 64'(busyn[1]), 64'(256));
      chk("t3_oe_bits", 1, 64'(capn[1]), 64'(64));
      chk("t3_bits", 1, cap[1], 64'hFFFF_FFFF_50C2_0001);

      // Bad OP then bad ST.
      r0 = risen[0];
      e0 = errn[0];
      issue(0, 32'h70C20000, 16'h0);
      issue(0, 32'h10C20000, 16'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("t4_err_pulses", 0, 64'(errn[0] - e0), 64'(2));
      chk("t4_mdc_rises", 0, 64'(risen[0] - r0), 64'(0));

      // Start re-pulsed mid-write must be ignored.
      issue(0, 32'h5F7E1111, 16'h0);
      repeat (40) @(posedge clk);
      #1;
      tdata[0] = 32'h6AAA5555;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      wait_idle(0, "t5");
      chk("t5_oe_bits", 0, 64'(capn[0]), 64'(32));
      chk("t5_frame", 0, 64'(cap[0][31:0]), 64'(32'h5F7E1111));
      chk("t5_rd_kept", 0, 64'(rdd[0]), 64'(16'h1234));

      // Reset during bit 10 of a read, then a clean read.
      issue(0, 32'h60C00000, 16'h5A5A);
      repeat (41) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_busy", 0, 64'(busy[0]), 64'(0));
      chk("t6_mdc", 0, 64'(mdc[0]), 64'(0));
      chk("t6_oe", 0, 64'(oe[0]), 64'(0));
      chk("t6_rd_cleared", 0, 64'(rdd[0]), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      issue(0, 32'h60C00000, 16'hBEEF);
      wait_idle(0, "t6");
      chk("t6_rd_data", 0, 64'(rdd[0]), 64'(16'hBEEF));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
